// File: rtl/mole_scheduler_if.sv
// Signal bundle between the game controller, its stimulus sources
// (tick divider, LFSR, switch edge detector) and the scoring path.
interface mole_scheduler_if;
  logic        start;
  logic        tick;
  logic [7:0]  rand_in;
  logic [7:0]  toggle;
  logic [7:0]  led;
  logic [3:0]  hit_amt;
  logic [3:0]  miss_amt;
  logic [3:0]  wrong_amt;
  logic [11:0] time_left;
  logic        busy;
  logic        game_over;

  modport master (
    output start, tick, rand_in, toggle,
    input  led, hit_amt, miss_amt, wrong_amt, time_left, busy, game_over
  );

  modport slave (
    input  start, tick, rand_in, toggle,
    output led, hit_amt, miss_amt, wrong_amt, time_left, busy, game_over
  );
endinterface

// File: rtl/mole_scheduler.sv
// Whack-a-mole game controller: picks which moles are up, times them out,
// turns switch toggle pulses into hit / miss / wrong counts and owns the
// round timer and game-over condition. All outputs come straight from flops.
module mole_scheduler #(
  parameter int UP_TICKS   = 50,
  parameter int GAP_TICKS  = 10,
  parameter int GAME_TICKS = 3000,
  parameter int MAX_MOLES  = 3
) (
  input  logic            game_clk,
  input  logic            rst,
  mole_scheduler_if.slave bus
);

  localparam int UP_W  = $clog2(UP_TICKS + 1);
  localparam int GAP_W = $clog2(GAP_TICKS + 1);

  localparam logic [UP_W-1:0]  UP_LOAD   = UP_W'(UP_TICKS);
  localparam logic [UP_W-1:0]  UP_ONE    = UP_W'(1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_TICKS);
  localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);
  localparam logic [11:0]      GAME_LOAD = 12'(GAME_TICKS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPAWN = 3'd1,
    ST_UP    = 3'd2,
    ST_GAP   = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Number of set bits in a byte; the result never exceeds 8.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  // Keep only the lowest MAX_MOLES set bits of a candidate mole mask.
  function automatic logic [7:0] keep_lowest(input logic [7:0] v);
    logic [7:0] r;
    int         n;
    r = 8'h00;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (v[i] && (n < MAX_MOLES)) begin
        r[i] = 1'b1;
        n    = n + 1;
      end else begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [7:0]       led_q, led_d;
  logic [3:0]       hit_amt_q, hit_amt_d;
  logic [3:0]       miss_amt_q, miss_amt_d;
  logic [3:0]       wrong_amt_q, wrong_amt_d;
  logic [11:0]      time_left_q, time_left_d;
  logic             busy_q, busy_d;
  logic             game_over_q, game_over_d;
  logic [UP_W-1:0]  up_cnt_q, up_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [2:0]       spawn_cnt_q, spawn_cnt_d;

  logic       in_round_s;
  logic       round_end_s;
  logic [7:0] remaining_s;
  logic [7:0] spawn_raw_s;

  // An all-zero random byte still has to put a mole up, so fall back to a
  // walking single bit driven by the spawn counter.
  assign in_round_s  = (state_q == ST_SPAWN) || (state_q == ST_UP) || (state_q == ST_GAP);
  assign round_end_s = in_round_s && bus.tick && (time_left_q == 12'd1);
  assign remaining_s = led_q & ~bus.toggle;
  assign spawn_raw_s = (bus.rand_in == 8'h00) ? (8'h01 << spawn_cnt_q) : bus.rand_in;

  // Next-state and next-output logic; round end outranks mole and gap timers.
  always_comb begin
    state_d     = state_q;
    led_d       = led_q;
    hit_amt_d   = 4'd0;
    miss_amt_d  = 4'd0;
    wrong_amt_d = 4'd0;
    time_left_d = time_left_q;
    up_cnt_d    = up_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    spawn_cnt_d = spawn_cnt_q;

    if (in_round_s) begin
      hit_amt_d   = popcount8(bus.toggle & led_q);
      wrong_amt_d = popcount8(bus.toggle & ~led_q);
      if (bus.tick) begin
        time_left_d = time_left_q - 12'd1;
      end else begin
        time_left_d = time_left_q;
      end
    end else begin
      hit_amt_d   = 4'd0;
      wrong_amt_d = 4'd0;
    end

    case (state_q)
      ST_IDLE, ST_OVER: begin
        led_d = 8'h00;
        if (bus.start) begin
          state_d     = ST_SPAWN;
          time_left_d = GAME_LOAD;
        end else begin
          state_d = state_q;
        end
      end
      ST_SPAWN: begin
        spawn_cnt_d = spawn_cnt_q + 3'd1;
        if (round_end_s) begin
          state_d = ST_OVER;
          led_d   = 8'h00;
        end else begin
          state_d  = ST_UP;
          led_d    = keep_lowest(spawn_raw_s);
          up_cnt_d = UP_LOAD;
        end
      end
      ST_UP: begin
        led_d = remaining_s;
        if (bus.tick) begin
          up_cnt_d = up_cnt_q - UP_ONE;
        end else begin
          up_cnt_d = up_cnt_q;
        end
        if (round_end_s) begin
          state_d    = ST_OVER;
          led_d      = 8'h00;
          miss_amt_d = popcount8(remaining_s);
        end else if (bus.tick && (up_cnt_q == UP_ONE)) begin
          state_d    = ST_GAP;
          led_d      = 8'h00;
          miss_amt_d = popcount8(remaining_s);
          gap_cnt_d  = GAP_LOAD;
        end else if (remaining_s == 8'h00) begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LOAD;
        end else begin
          state_d = state_q;
        end
      end
      ST_GAP: begin
        led_d = 8'h00;
        if (bus.tick) begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end else begin
          gap_cnt_d = gap_cnt_q;
        end
        if (round_end_s) begin
          state_d = ST_OVER;
        end else if (bus.tick && (gap_cnt_q == GAP_ONE)) begin
          state_d = ST_SPAWN;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        led_d   = 8'h00;
      end
    endcase

    busy_d      = (state_d == ST_SPAWN) || (state_d == ST_UP) || (state_d == ST_GAP);
    game_over_d = (state_d == ST_OVER);
  end

  // State and output registers; reset aborts any round and goes dark at once.
  always_ff @(posedge game_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      led_q       <= 8'h00;
      hit_amt_q   <= 4'd0;
      miss_amt_q  <= 4'd0;
      wrong_amt_q <= 4'd0;
      time_left_q <= 12'd0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
      up_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      spawn_cnt_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      led_q       <= led_d;
      hit_amt_q   <= hit_amt_d;
      miss_amt_q  <= miss_amt_d;
      wrong_amt_q <= wrong_amt_d;
      time_left_q <= time_left_d;
      busy_q      <= busy_d;
      game_over_q <= game_over_d;
      up_cnt_q    <= up_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      spawn_cnt_q <= spawn_cnt_d;
    end
  end

  assign bus.led       = led_q;
  assign bus.hit_amt   = hit_amt_q;
  assign bus.miss_amt  = miss_amt_q;
  assign bus.wrong_amt = wrong_amt_q;
  assign bus.time_left = time_left_q;
  assign bus.busy      = busy_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler: a default-sized instance and a short-round
// instance, both tracked every cycle by a behavioural game model, plus a
// vector table and hand-written corner-case sequences.
module tb_mole_scheduler;
  localparam int A_UP = 50, A_GAP = 10, A_GAME = 3000, A_MAX = 3;
  localparam int B_UP = 4,  B_GAP = 2,  B_GAME = 5,    B_MAX = 3;

  localparam int P_IDLE = 0, P_SPAWN = 1, P_UP = 2, P_GAP = 3, P_OVER = 4;

  logic game_clk = 1'b0;
  logic rst_a, rst_b;
  int   checks   = 0;
  int   failures = 0;

  mole_scheduler_if ifa ();
  mole_scheduler_if ifb ();

  always #5 game_clk = ~game_clk;

  mole_scheduler #(.UP_TICKS(A_UP), .GAP_TICKS(A_GAP), .GAME_TICKS(A_GAME), .MAX_MOLES(A_MAX))
    dut_a (.game_clk(game_clk), .rst(rst_a), .bus(ifa));
  mole_scheduler #(.UP_TICKS(B_UP), .GAP_TICKS(B_GAP), .GAME_TICKS(B_GAME), .MAX_MOLES(B_MAX))
    dut_b (.game_clk(game_clk), .rst(rst_b), .bus(ifb));

  // Behavioural game state: what the player would see, not how it is built.
  typedef struct {
    int         phase;
    logic [7:0] led;
    int         up_left;
    int         gap_left;
    int         time_left;
    int         spawns;
    int         hit;
    int         miss;
    int         wrong;
  } mdl_t;

  typedef struct {
    logic        start;
    logic        tick;
    logic [7:0]  rnd;
    logic [7:0]  tog;
    logic [7:0]  e_led;
    logic [3:0]  e_hit;
    logic [3:0]  e_miss;
    logic [3:0]  e_wrong;
    logic [11:0] e_time;
    logic        e_busy;
    logic        e_over;
  } vec_t;

  mdl_t ma, mb;
  vec_t tbl [0:6];

  function automatic mdl_t mstep(input mdl_t m, input bit r, input bit s, input bit t,
                                 input logic [7:0] rnd, input logic [7:0] tog,
                                 input int upt, input int gapt, input int gamet, input int maxm);
    mdl_t       n;
    logic [7:0] rest;
    logic [7:0] mask;
    int         kept;
    n = m;
    n.hit = 0; n.miss = 0; n.wrong = 0;
    if (r) begin
      n.phase = P_IDLE; n.led = 8'h00; n.up_left = 0; n.gap_left = 0;
      n.time_left = 0; n.spawns = 0;
      return n;
    end
    if (m.phase == P_IDLE || m.phase == P_OVER) begin
      n.led = 8'h00;
      if (s) begin
        n.phase = P_SPAWN;
        n.time_left = gamet;
      end
      return n;
    end
    n.hit   = $countones(tog & m.led);
    n.wrong = $countones(tog & ~m.led);
    rest    = m.led & ~tog;
    if (t) n.time_left = m.time_left - 1;
    if (m.phase == P_SPAWN) n.spawns = (m.spawns + 1) % 8;
    if (t && m.time_left == 1) begin
      n.phase = P_OVER; n.led = 8'h00; n.miss = $countones(rest);
      return n;
    end
    case (m.phase)
      P_SPAWN: begin
        mask = (rnd != 8'h00) ? rnd : 8'(1 << m.spawns);
        n.led = 8'h00;
        kept = 0;
        for (int i = 0; i < 8; i++) begin
          if (mask[i] && kept < maxm) begin
            n.led[i] = 1'b1;
            kept++;
          end
        end
        n.phase = P_UP;
        n.up_left = upt;
      end
      P_UP: begin
        n.led = rest;
        if (t) n.up_left = m.up_left - 1;
        if (t && n.up_left == 0) begin
          n.miss = $countones(rest); n.led = 8'h00; n.phase = P_GAP; n.gap_left = gapt;
        end else if (rest == 8'h00) begin
          n.phase = P_GAP; n.gap_left = gapt;
        end
      end
      default: begin
        n.led = 8'h00;
        if (t) n.gap_left = m.gap_left - 1;
        if (t && n.gap_left == 0) n.phase = P_SPAWN;
      end
    endcase
    return n;
  endfunction

  function automatic logic [33:0] pack(input mdl_t m);
    return {m.led, 4'(m.hit), 4'(m.miss), 4'(m.wrong), 12'(m.time_left),
            (m.phase == P_SPAWN || m.phase == P_UP || m.phase == P_GAP), (m.phase == P_OVER)};
  endfunction

  function automatic vec_t mk(input logic s, input logic t, input logic [7:0] rnd,
                              input logic [7:0] tog, input logic [7:0] led, input logic [3:0] h,
                              input logic [3:0] mi, input logic [3:0] w, input logic [11:0] tl,
                              input logic b, input logic o);
    vec_t v;
    v.start = s; v.tick = t; v.rnd = rnd; v.tog = tog; v.e_led = led; v.e_hit = h;
    v.e_miss = mi; v.e_wrong = w; v.e_time = tl; v.e_busy = b; v.e_over = o;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkv(input string nm, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step_a(input bit s, input bit t, input logic [7:0] rnd, input logic [7:0] tog);
    ifa.start = s; ifa.tick = t; ifa.rand_in = rnd; ifa.toggle = tog;
    @(posedge game_clk); #1;
  endtask

  task automatic step_b(input bit s, input bit t, input logic [7:0] rnd, input logic [7:0] tog);
    ifb.start = s; ifb.tick = t; ifb.rand_in = rnd; ifb.toggle = tog;
    @(posedge game_clk); #1;
  endtask

  // Advance both reference models with the inputs seen at this edge.
  always @(posedge game_clk) begin
    ma <= mstep(ma, rst_a, ifa.start, ifa.tick, ifa.rand_in, ifa.toggle, A_UP, A_GAP, A_GAME, A_MAX);
    mb <= mstep(mb, rst_b, ifb.start, ifb.tick, ifb.rand_in, ifb.toggle, B_UP, B_GAP, B_GAME, B_MAX);
  end

  // Compare every output of both instances against the model mid-cycle.
  always @(negedge game_clk) begin
    chkv("model_a", {ifa.led, ifa.hit_amt, ifa.miss_amt, ifa.wrong_amt, ifa.time_left,
                     ifa.busy, ifa.game_over}, pack(ma));
    chkv("model_b", {ifb.led, ifb.hit_amt, ifb.miss_amt, ifb.wrong_amt, ifb.time_left,
                     ifb.busy, ifb.game_over}, pack(mb));
  end

  initial begin
    logic [7:0] exp_led;
    logic [7:0] tog;
    bit         t;

    rst_a = 1'b1; rst_b = 1'b1;
    ifa.start = 1'b1; ifa.tick = 1'b0; ifa.rand_in = 8'h00; ifa.toggle = 8'h00;
    ifb.start = 1'b0; ifb.tick = 1'b0; ifb.rand_in = 8'h00; ifb.toggle = 8'h00;

    // Reset wins over a held start.
    step_a(1'b1, 1'b0, 8'h00, 8'h00);
    step_a(1'b1, 1'b1, 8'hFF, 8'hFF);
    chk("rst_led", ifa.led, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_over", ifa.game_over, 0);
    chk("rst_time", ifa.time_left, 0);
    chk("rst_counts", {ifa.hit_amt, ifa.miss_amt, ifa.wrong_amt}, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    step_a(1'b0, 1'b0, 8'h00, 8'h00);
    chk("idle_busy", ifa.busy, 0);

    tbl[0] = mk(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 4'd0, 4'd0, 4'd0, 12'd3000, 1'b1, 1'b0);
    tbl[1] = mk(1'b0, 1'b0, 8'hB6, 8'h00, 8'h16, 4'd0, 4'd0, 4'd0, 12'd3000, 1'b1, 1'b0);
    tbl[2] = mk(1'b0, 1'b0, 8'h00, 8'h04, 8'h12, 4'd1, 4'd0, 4'd0, 12'd3000, 1'b1, 1'b0);
    tbl[3] = mk(1'b0, 1'b0, 8'h00, 8'h82, 8'h10, 4'd1, 4'd0, 4'd1, 12'd3000, 1'b1, 1'b0);
    tbl[4] = mk(1'b1, 1'b1, 8'h00, 8'h00, 8'h10, 4'd0, 4'd0, 4'd0, 12'd2999, 1'b1, 1'b0);
    tbl[5] = mk(1'b0, 1'b0, 8'h00, 8'h10, 8'h00, 4'd1, 4'd0, 4'd0, 12'd2999, 1'b1, 1'b0);
    tbl[6] = mk(1'b0, 1'b0, 8'h00, 8'h01, 8'h00, 4'd0, 4'd0, 4'd1, 12'd2999, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step_a(tbl[i].start, tbl[i].tick, tbl[i].rnd, tbl[i].tog);
      chkv($sformatf("table_%0d", i),
           {ifa.led, ifa.hit_amt, ifa.miss_amt, ifa.wrong_amt, ifa.time_left, ifa.busy, ifa.game_over},
           {tbl[i].e_led, tbl[i].e_hit, tbl[i].e_miss, tbl[i].e_wrong, tbl[i].e_time,
            tbl[i].e_busy, tbl[i].e_over});
    end

    // Finish the gap, then three all-zero spawns that walk a single mole.
    for (int g = 0; g < A_GAP; g++) step_a(1'b0, 1'b1, 8'h00, 8'h00);
    for (int k = 0; k < 3; k++) begin
      exp_led = 8'h02 << k;
      step_a(1'b0, 1'b0, 8'h00, 8'h00);
      chk($sformatf("zero_spawn_led_%0d", k), ifa.led, exp_led);
      for (int j = 0; j < A_UP - 1; j++) step_a(1'b0, 1'b1, 8'($urandom), 8'h00);
      chk("up_held_led", ifa.led, exp_led);
      step_a(1'b0, 1'b1, 8'h00, 8'h00);
      chk("timeout_miss", ifa.miss_amt, 1);
      chk("timeout_led", ifa.led, 0);
      step_a(1'b0, 1'b0, 8'h00, 8'h00);
      chk("miss_one_cycle", ifa.miss_amt, 0);
      for (int g = 0; g < A_GAP; g++) begin
        step_a(1'b0, 1'b1, 8'h00, 8'h00);
        chk("gap_dark", ifa.led, 0);
      end
    end
    chk("time_after_walk", ifa.time_left, 2809);

    // Hit and wrong switch in the same cycle.
    step_a(1'b0, 1'b0, 8'h01, 8'h00);
    step_a(1'b0, 1'b0, 8'h00, 8'h81);
    chk("both_hit", ifa.hit_amt, 1);
    chk("both_wrong", ifa.wrong_amt, 1);

    // Reset in the middle of a mole set: dark immediately, no miss pulse.
    for (int g = 0; g < A_GAP; g++) step_a(1'b0, 1'b1, 8'h00, 8'h00);
    step_a(1'b0, 1'b0, 8'hFF, 8'h00);
    chk("pre_rst_led", ifa.led, 8'h07);
    rst_a = 1'b1;
    step_a(1'b0, 1'b0, 8'h00, 8'h00);
    chk("mid_rst_led", ifa.led, 0);
    chk("mid_rst_busy", ifa.busy, 0);
    chk("mid_rst_miss", ifa.miss_amt, 0);
    rst_a = 1'b0;
    step_a(1'b0, 1'b0, 8'h00, 8'h00);
    chk("post_rst_miss", ifa.miss_amt, 0);

    // Short round: hit on the final tick, which also coincides with the mole timeout.
    step_b(1'b1, 1'b0, 8'h00, 8'h00);
    step_b(1'b0, 1'b1, 8'h07, 8'h00);
    chk("b_spawn_led", ifb.led, 8'h07);
    chk("b_spawn_time", ifb.time_left, 4);
    for (int j = 0; j < 3; j++) step_b(1'b0, 1'b1, 8'h00, 8'h00);
    chk("b_last_time", ifb.time_left, 1);
    step_b(1'b0, 1'b1, 8'h00, 8'h01);
    chk("b_end_hit", ifb.hit_amt, 1);
    chk("b_end_miss", ifb.miss_amt, 2);
    chk("b_end_over", ifb.game_over, 1);
    chk("b_end_led", ifb.led, 0);
    chk("b_end_busy", ifb.busy, 0);
    step_b(1'b1, 1'b0, 8'h00, 8'h00);
    chk("b_restart_busy", ifb.busy, 1);
    chk("b_restart_over", ifb.game_over, 0);
    chk("b_restart_time", ifb.time_left, 5);

    // Random play on both instances; the per-cycle model check does the work.
    for (int c = 0; c < 5000; c++) begin
      rst_a = ($urandom_range(0, 2999) == 0);
      rst_b = rst_a;
      t = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0, 1:    tog = 8'h00;
        2:       tog = (ma.led | mb.led) & (8'h01 << $urandom_range(0, 7));
        default: tog = 8'($urandom);
      endcase
      ifb.start = ($urandom_range(0, 7) == 0);
      ifb.tick = t;
      ifb.rand_in = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      ifb.toggle = tog;
      step_a(ifb.start, t, ifb.rand_in, tog);
    end
    rst_a = 1'b0; rst_b = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
